// File: rtl/wasm_mem_arbiter.sv
// wasm_mem_arbiter
//   Shares the single wasm_memory read/write port between the wasm_cpu
//   memory interface and a host-side requester (debug / DMA loader).
//   One transaction is outstanding at a time. The CPU has priority, but the
//   host wins after CPU_BURST_MAX consecutive CPU grants while it is waiting.
//   Hung accesses are aborted after TIMEOUT_CYCLES cycles in WAIT.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   cpu_* / host_*          request (req/we/addr/op/wdata) and response
//                           (ack/rdata/err) for each requester
//   mem_rd_* / mem_wr_*     strobes, address, op and data to wasm_memory
//   mem_rd_data_i, mem_rd_valid_i, mem_wr_valid_i, mem_trap_i
//                           memory completion and trap code
//   owner_o                 0=CPU, 1=host (meaningful while busy_o=1)
//   busy_o                  arbiter not in IDLE
//   timeout_o               sticky timeout flag, cleared by reset only

package wasm_mem_pkg;
  typedef enum logic [2:0] {
    OP_8S  = 3'd0,
    OP_8U  = 3'd1,
    OP_16S = 3'd2,
    OP_16U = 3'd3,
    OP_32S = 3'd4,
    OP_32U = 3'd5,
    OP_64  = 3'd6
  } mem_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE      = 2'd0,
    TRAP_OOB       = 2'd1,
    TRAP_UNALIGNED = 2'd2
  } trap_t;
endpackage

module wasm_mem_arbiter
  import wasm_mem_pkg::*;
#(
  parameter int CPU_BURST_MAX  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  mem_op_t     cpu_op_i,
  input  logic [63:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [63:0] cpu_rdata_o,
  output logic        cpu_err_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  mem_op_t     host_op_i,
  input  logic [63:0] host_wdata_i,
  output logic        host_ack_o,
  output logic [63:0] host_rdata_o,
  output logic        host_err_o,
  output logic        mem_rd_en_o,
  output logic [31:0] mem_rd_addr_o,
  output mem_op_t     mem_rd_op_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_wr_addr_o,
  output mem_op_t     mem_wr_op_o,
  output logic [63:0] mem_wr_data_o,
  input  logic [63:0] mem_rd_data_i,
  input  logic        mem_rd_valid_i,
  input  logic        mem_wr_valid_i,
  input  trap_t       mem_trap_i,
  output logic        owner_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int SW = $clog2(CPU_BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic          owner_reg;
  logic          we_reg;
  logic [31:0]   addr_reg;
  mem_op_t       op_reg;
  logic [63:0]   wdata_reg;
  logic [SW-1:0] starve_cnt_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [63:0]   cpu_rdata_reg, host_rdata_reg;
  logic          cpu_err_reg, host_err_reg;
  logic          timeout_reg;

  logic          any_req;
  logic          host_wins;
  logic          match_valid;
  logic          capture;
  logic          timed_out;
  logic [63:0]   cap_data;
  logic          cap_err;

  assign any_req     = cpu_req_i | host_req_i;
  // Host wins when alone, or when the CPU has used up its burst allowance.
  assign host_wins   = host_req_i & (~cpu_req_i | (starve_cnt_reg == SW'(CPU_BURST_MAX)));
  assign match_valid = we_reg ? mem_wr_valid_i : mem_rd_valid_i;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      IDLE:  if (any_req) state_next = ISSUE;
      ISSUE: begin
        // A zero-latency memory may complete in the issue cycle itself.
        state_next = WAIT;
        if (match_valid) begin
          state_next = RESP;
          capture    = 1'b1;
        end
      end
      WAIT: begin
        if (match_valid) begin
          state_next = RESP;
          capture    = 1'b1;
        end else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next = RESP;
          capture    = 1'b1;
          timed_out  = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writes and timeouts return zero data; a timeout always reports an error.
  assign cap_data = (timed_out | we_reg) ? 64'd0 : mem_rd_data_i;
  assign cap_err  = timed_out | (mem_trap_i != TRAP_NONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      op_reg         <= OP_8S;
      wdata_reg      <= '0;
      starve_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      cpu_rdata_reg  <= '0;
      host_rdata_reg <= '0;
      cpu_err_reg    <= 1'b0;
      host_err_reg   <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE) begin
        if (any_req) begin
          owner_reg <= host_wins;
          we_reg    <= host_wins ? host_we_i    : cpu_we_i;
          addr_reg  <= host_wins ? host_addr_i  : cpu_addr_i;
          op_reg    <= host_wins ? host_op_i    : cpu_op_i;
          wdata_reg <= host_wins ? host_wdata_i : cpu_wdata_i;
        end
        if (!host_req_i || (any_req && host_wins)) begin
          starve_cnt_reg <= '0;
        end else if (any_req && starve_cnt_reg != SW'(CPU_BURST_MAX)) begin
          // CPU grant with the host waiting.
          starve_cnt_reg <= starve_cnt_reg + SW'(1);
        end
      end

      if (state_reg == ISSUE) begin
        tmo_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      end

      if (capture) begin
        if (owner_reg) begin
          host_rdata_reg <= cap_data;
          host_err_reg   <= cap_err;
        end else begin
          cpu_rdata_reg <= cap_data;
          cpu_err_reg   <= cap_err;
        end
      end

      if (timed_out) timeout_reg <= 1'b1;
    end
  end

  assign cpu_ack_o     = (state_reg == RESP) & ~owner_reg;
  assign host_ack_o    = (state_reg == RESP) &  owner_reg;
  assign cpu_rdata_o   = cpu_rdata_reg;
  assign cpu_err_o     = cpu_err_reg;
  assign host_rdata_o  = host_rdata_reg;
  assign host_err_o    = host_err_reg;
  assign mem_rd_en_o   = (state_reg == ISSUE) & ~we_reg;
  assign mem_wr_en_o   = (state_reg == ISSUE) &  we_reg;
  assign mem_rd_addr_o = addr_reg;
  assign mem_rd_op_o   = op_reg;
  assign mem_wr_addr_o = addr_reg;
  assign mem_wr_op_o   = op_reg;
  assign mem_wr_data_o = wdata_reg;
  assign owner_o       = owner_reg;
  assign busy_o        = (state_reg != IDLE);
  assign timeout_o     = timeout_reg;

endmodule
